b_muldiv_unit: RTL

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS five-stage pipeline. It sits beside the EX-stage ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It raises a stall request to hazard control whenever a dependent instruction reaches EX while an operation is still in flight. Multiply uses a radix-2 shift-add datapath and divide uses a restoring datapath, both sequenced by an internal FSM with a fixed latency.

---
 rtl/b_muldiv_unit.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/b_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide share one 64-bit working register.
module b_muldiv_unit (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_b_muldiv_start,
    input  logic [2:0]  i_b_muldiv_op,
    input  logic [31:0] i_b_muldiv_operand_1,
    input  logic [31:0] i_b_muldiv_operand_2,
    input  logic        i_b_muldiv_rd_req,
    input  logic        i_b_muldiv_flush,
    output logic        o_b_muldiv_busy,
    output logic        o_b_muldiv_stall,
    output logic        o_b_muldiv_done,
    output logic [31:0] o_b_muldiv_hi,
    output logic [31:0] o_b_muldiv_lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] op_b;
    logic [31:0] dividend_raw;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;

    logic        is_signed;
    logic        sign_1;
    logic        sign_2;
    logic [31:0] abs_1;
    logic [31:0] abs_2;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    logic [63:0] prod_neg;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign is_signed = ~i_b_muldiv_op[0];
    assign sign_1    = is_signed & i_b_muldiv_operand_1[31];
    assign sign_2    = is_signed & i_b_muldiv_operand_2[31];
    assign abs_1     = sign_1 ? -i_b_muldiv_operand_1 : i_b_muldiv_operand_1;
    assign abs_2     = sign_2 ? -i_b_muldiv_operand_2 : i_b_muldiv_operand_2;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step
    assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, op_b} : 33'd0);
    assign mul_next  = {mul_sum, acc[31:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left each step
    assign div_shift = {acc[63:32], acc[31]};
    assign div_trial = div_shift - {1'b0, op_b};
    assign div_next  = div_trial[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                     : {div_trial[31:0], acc[30:0], 1'b1};

    assign prod_neg  = neg_q ? -acc : acc;
    assign quo_fix   = neg_q ? -acc[31:0] : acc[31:0];
    assign rem_fix   = neg_r ? -acc[63:32] : acc[63:32];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            count        <= 5'd0;
            acc          <= 64'd0;
            op_b         <= 32'd0;
            dividend_raw <= 32'd0;
            is_div       <= 1'b0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_zero     <= 1'b0;
            hi           <= 32'd0;
            lo           <= 32'd0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_b_muldiv_start && !i_b_muldiv_flush) begin
                        if (!i_b_muldiv_op[2]) begin
                            state        <= CALC;
                            count        <= 5'd31;
                            acc          <= {32'd0, abs_1};
                            op_b         <= abs_2;
                            dividend_raw <= i_b_muldiv_operand_1;
                            is_div       <= i_b_muldiv_op[1];
                            neg_q        <= sign_1 ^ sign_2;
                            neg_r        <= sign_1;
                            div_zero     <= (i_b_muldiv_operand_2 == 32'd0);
                        end else if (i_b_muldiv_op[1:0] == 2'b00) begin
                            hi <= i_b_muldiv_operand_1;
                        end else if (i_b_muldiv_op[1:0] == 2'b01) begin
                            lo <= i_b_muldiv_operand_1;
                        end
                    end
                end
                CALC: begin
                    if (i_b_muldiv_flush) begin
                        state <= IDLE;
                    end else begin
                        acc   <= is_div ? div_next : mul_next;
                        count <= count - 5'd1;
                        if (count == 5'd0) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!i_b_muldiv_flush) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            hi <= prod_neg[63:32];
                            lo <= prod_neg[31:0];
                        end else if (div_zero) begin
                            hi <= dividend_raw;
                            lo <= 32'hFFFF_FFFF;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_b_muldiv_busy  = (state != IDLE);
    assign o_b_muldiv_stall = o_b_muldiv_busy & (i_b_muldiv_start | i_b_muldiv_rd_req);
    assign o_b_muldiv_done  = done;
    assign o_b_muldiv_hi    = hi;
    assign o_b_muldiv_lo    = lo;

endmodule
